// File: rtl/dmux_reg_bank_pkg.sv
// Shared constants for the 16-bit register-bank family (RAM8 leaf, reused by
// the RAM64/RAM512 levels above it).
//   HACK_WORD_W    : data word width
//   RAM8_ADDR_W    : address width of one leaf bank
//   RAM8_DEPTH     : registers per leaf bank
//   HACK_WORD_ZERO : reset value of every storage word
package dmux_reg_bank_pkg;

  localparam int HACK_WORD_W = 16;
  localparam int RAM8_ADDR_W = 3;
  localparam int RAM8_DEPTH  = 1 << RAM8_ADDR_W;

  localparam logic [HACK_WORD_W-1:0] HACK_WORD_ZERO = 16'h0000;

endpackage : dmux_reg_bank_pkg

// File: rtl/dmux_reg_bank_register16.sv
// register16: WIDTH-bit D register with load enable and asynchronous
// active-high clear. One instance per word of the bank.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high clear
//   load : capture d on the next rising edge when high
//   d    : data in
//   q    : stored word
module register16
  import dmux_reg_bank_pkg::*;
#(
  parameter int WIDTH = HACK_WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // bank samples its inputs from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= WIDTH'(HACK_WORD_ZERO);
    end else if (load) begin
      q <= d;
    end
  end

endmodule : register16

// File: rtl/dmux_reg_bank.sv
// dmux_reg_bank: RAM8-style leaf storage. One write word is demultiplexed to
// the register selected by addr; a 2:1 mux tree returns register[addr].
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset (clears all words and wr_ack)
//   in     : write data
//   load   : write enable, sampled on rising clk
//   addr   : shared read/write address
//   out    : register[addr], combinational, shows old data in the write cycle
//   wr_ack : high for the cycle after each accepted write
module dmux_reg_bank
  import dmux_reg_bank_pkg::*;
#(
  parameter int WIDTH  = HACK_WORD_W,
  parameter int ADDR_W = RAM8_ADDR_W,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] addr,
  output logic [WIDTH-1:0]  out,
  output logic              wr_ack
);

  if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
    $error("dmux_reg_bank: DEPTH (%0d) must equal 1 << ADDR_W (%0d)",
           DEPTH, 1 << ADDR_W);
  end

  // Heap-ordered read tree: node n has children 2n+1 / 2n+2, leaves sit at
  // DEPTH-1+i. The root is steered by the address MSB, so leaf order matches
  // register index order.
  logic [WIDTH-1:0] node [2*DEPTH-1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic word_load;

    // Load demux: exactly one word sees load when load is high.
    assign word_load = load && (addr == ADDR_W'(i));

    // NOTE: every storage word is reset; the bank is small and the interface
    // promises out = 0 for all addresses immediately after reset.
    register16 #(.WIDTH(WIDTH)) u_word (
      .clk  (clk),
      .rst  (rst),
      .load (word_load),
      .d    (in),
      .q    (node[DEPTH-1+i])
    );
  end

  for (genvar n = 0; n < DEPTH-1; n++) begin : g_mux
    localparam int LEVEL = $clog2(n + 2) - 1;
    localparam int SEL   = ADDR_W - 1 - LEVEL;

    assign node[n] = addr[SEL] ? node[2*n+2] : node[2*n+1];
  end

  assign out = node[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= load;
    end
  end

endmodule : dmux_reg_bank

// File: tb/tb_dmux_reg_bank.sv
// Self-checking bench for dmux_reg_bank: directed scenarios plus random
// traffic, all predicted by an array-based memory model. Stimulus pushes the
// expected out/wr_ack of each cycle into a queue; a monitor pops and compares
// on the falling edge.
module tb_dmux_reg_bank;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic              clk;
  logic              rst;
  logic [WIDTH-1:0]  in;
  logic              load;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  out;
  logic              wr_ack;

  dmux_reg_bank #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
    .load   (load),
    .addr   (addr),
    .out    (out),
    .wr_ack (wr_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Writing through an unknown address is illegal.
  always @(posedge clk) begin
    if (load === 1'b1) begin
      assert (!$isunknown(addr)) else $error("load high with unknown addr");
    end
  end

  typedef struct {
    int               cyc;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0] out;
    logic             ack;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_no   = 0;

  // Reference model: the bank as a plain array plus last-cycle write flag.
  logic [WIDTH-1:0] model_mem [DEPTH];
  logic             model_ack;

  task automatic check(input string name, input int cyc, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] want);
    n_checks++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, want);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("out[addr=%0d]", e.addr), e.cyc, out, e.out);
        check("wr_ack", e.cyc, {15'b0, wr_ack}, {15'b0, e.ack});
      end
    end
  end

  // One clock cycle of stimulus; entered and left at posedge + 1.
  task automatic cycle(input logic rst_v, input logic load_v,
                       input logic [ADDR_W-1:0] addr_v, input logic [WIDTH-1:0] in_v);
    exp_t e;
    rst  = rst_v;
    load = load_v;
    addr = addr_v;
    in   = in_v;
    if (rst_v) begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      model_ack = 1'b0;
    end
    e.cyc  = cyc_no;
    e.addr = addr_v;
    e.out  = model_mem[addr_v];
    e.ack  = model_ack;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc_no++;
    if (!rst_v) begin
      model_ack = load_v;
      if (load_v) model_mem[addr_v] = in_v;
    end
  endtask

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    addr = '0;
    in   = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_ack = 1'b0;
    @(posedge clk);
    #1;

    // Reset state, load ignored while rst is high.
    cycle(1'b1, 1'b0, 3'd0, 16'h0000);
    cycle(1'b1, 1'b1, 3'd4, 16'h5555);

    // Fill with ones, then pulse reset and read every address.
    for (int k = 0; k < DEPTH; k++) cycle(1'b0, 1'b1, 3'(k), 16'hFFFF);
    for (int k = 0; k < DEPTH; k++) cycle(1'b1, 1'b0, 3'(k), 16'h0000);

    // Walk: back-to-back writes, then read everything back.
    for (int k = 0; k < DEPTH; k++) cycle(1'b0, 1'b1, 3'(k), 16'h1000 + 16'(k));
    for (int k = 0; k < DEPTH; k++) cycle(1'b0, 1'b0, 3'(k), 16'h0000);

    // Isolation: one write to addr 5, others unchanged.
    cycle(1'b0, 1'b1, 3'd5, 16'ha211);
    for (int k = 0; k < DEPTH; k++) cycle(1'b0, 1'b0, 3'(k), 16'h0000);

    // Same-cycle read/write shows old data, new data afterwards.
    cycle(1'b0, 1'b1, 3'd2, 16'h0730);
    cycle(1'b0, 1'b1, 3'd2, 16'h0090);
    cycle(1'b0, 1'b0, 3'd2, 16'h0000);

    // load=0 hold with data present on in.
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 3'd1, 16'h1001);

    // Reset during a write, then one write after release.
    cycle(1'b0, 1'b1, 3'd6, 16'h7777);
    cycle(1'b1, 1'b1, 3'd6, 16'h0003);
    cycle(1'b0, 1'b0, 3'd6, 16'h0000);
    cycle(1'b0, 1'b1, 3'd6, 16'h0003);
    cycle(1'b0, 1'b0, 3'd6, 16'h0000);

    // Random traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, DEPTH-1)), 16'($urandom));
    end

    // Drain the scoreboard with a bounded wait.
    begin
      int budget = 10;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        n_checks++;
        $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_dmux_reg_bank
